// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI target core. Oversamples sclk/ss/mosi with wb_clk_i and
//               shifts WIDTH-bit words in all four CPOL/CPHA modes, MSB/LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb,
    input  logic [WIDTH-1:0] tx_dat_i,
    input  logic             tx_vld_i,
    output logic             tx_rdy_o,
    output logic [WIDTH-1:0] rx_dat_o,
    output logic             rx_vld_o,
    output logic             tx_unf_o,
    output logic             busy_o,
    input  logic             ss_pad_i,
    input  logic             sclk_pad_i,
    input  logic             mosi_pad_i,
    output logic             miso_pad_o,
    output logic             miso_oe_o
);

    localparam int               c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_d;
    logic                   r_sclk_d;

    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_lsb;

    logic [WIDTH-1:0]       r_hold;
    logic                   r_hold_full;
    logic [WIDTH-1:0]       r_shift_tx;
    logic [WIDTH-1:0]       r_shift_rx;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic                   r_done;
    logic [WIDTH-1:0]       r_rx_dat;
    logic                   r_rx_vld;
    logic                   r_tx_unf;
    logic                   r_miso;

    logic                   w_ss_s;
    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_ss_fall;
    logic                   w_edge;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift_edge;
    logic                   w_load;
    logic                   w_busy;
    logic                   w_ld_cpha;
    logic                   w_ld_lsb;
    logic [WIDTH-1:0]       w_ld_word;
    logic                   w_hold_wr;

    function automatic logic f_first(input logic [WIDTH-1:0] v, input logic l);
        return l ? v[0] : v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] f_adv(input logic [WIDTH-1:0] v, input logic l);
        return l ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
    endfunction

    // Pad synchronizers; ss resets low so a select held low through reset never looks like a fall.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_pad_i};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_pad_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_pad_i};
            r_ss_d      <= w_ss_s;
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_fall = r_ss_d & ~w_ss_s;

    assign w_edge    = w_sclk_s ^ r_sclk_d;
    assign w_lead    = w_edge & (w_sclk_s != r_cpol);
    assign w_trail   = w_edge & (w_sclk_s == r_cpol);
    assign w_sample  = (r_state == ST_SHIFT) & (r_cpha ? w_trail : w_lead);
    // With cpha=0 the word-load already drove bit 0, so the shift edge at count 0 is skipped.
    assign w_shift_edge = (r_state == ST_SHIFT) & ~w_ss_s & (r_cpha ? w_lead : w_trail)
                        & ~(~r_cpha & (r_bit_cnt == '0));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_busy = 1'b1;
                if (w_ss_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_done) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The load at ss fall must use the live mode pins since they latch in that same cycle.
    assign w_ld_cpha = (r_state == ST_IDLE) ? cpha : r_cpha;
    assign w_ld_lsb  = (r_state == ST_IDLE) ? lsb  : r_lsb;
    assign w_ld_word = r_hold_full ? r_hold : '0;
    assign w_hold_wr = tx_vld_i & ~r_hold_full;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_lsb       <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift_tx  <= '0;
            r_shift_rx  <= '0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
            r_rx_dat    <= '0;
            r_rx_vld    <= 1'b0;
            r_tx_unf    <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_rx_vld <= 1'b0;
            r_tx_unf <= 1'b0;

            if (w_load && (r_state == ST_IDLE)) begin
                r_cpol <= cpol;
                r_cpha <= cpha;
                r_lsb  <= lsb;
            end

            if (w_hold_wr) begin
                r_hold      <= tx_dat_i;
                r_hold_full <= 1'b1;
            end

            if (r_done) begin
                r_rx_dat <= r_shift_rx;
                r_rx_vld <= 1'b1;
                r_done   <= 1'b0;
            end

            if (w_sample) begin
                r_shift_rx <= r_lsb ? {w_mosi_s, r_shift_rx[WIDTH-1:1]}
                                    : {r_shift_rx[WIDTH-2:0], w_mosi_s};
                r_bit_cnt  <= r_bit_cnt + c_one;
                if (r_bit_cnt == c_last) begin
                    r_done <= 1'b1;
                end
            end

            if (w_shift_edge) begin
                r_miso     <= f_first(r_shift_tx, r_lsb);
                r_shift_tx <= f_adv(r_shift_tx, r_lsb);
            end

            if (w_load) begin
                r_bit_cnt <= '0;
                r_tx_unf  <= ~r_hold_full;
                if (r_hold_full) begin
                    r_hold_full <= 1'b0;
                end
                if (!w_ld_cpha) begin
                    r_miso     <= f_first(w_ld_word, w_ld_lsb);
                    r_shift_tx <= f_adv(w_ld_word, w_ld_lsb);
                end else begin
                    r_shift_tx <= w_ld_word;
                end
            end

            if ((r_state == ST_SHIFT) && w_ss_s) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end
        end
    end

    assign tx_rdy_o   = ~r_hold_full;
    assign rx_dat_o   = r_rx_dat;
    assign rx_vld_o   = r_rx_vld;
    assign tx_unf_o   = r_tx_unf;
    assign busy_o     = w_busy;
    assign miso_oe_o  = w_busy;
    assign miso_pad_o = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Randomized bench for spi_slave with a bit-level SPI master
//               model and word-level expected traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpol, cpha, lsb;
    logic [WIDTH-1:0] tx_dat;
    logic             tx_vld;
    logic             tx_rdy;
    logic [WIDTH-1:0] rx_dat;
    logic             rx_vld;
    logic             tx_unf;
    logic             busy;
    logic             ss, sclk, mosi;
    logic             miso, miso_oe;

    spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsb        (lsb),
        .tx_dat_i   (tx_dat),
        .tx_vld_i   (tx_vld),
        .tx_rdy_o   (tx_rdy),
        .rx_dat_o   (rx_dat),
        .rx_vld_o   (rx_vld),
        .tx_unf_o   (tx_unf),
        .busy_o     (busy),
        .ss_pad_i   (ss),
        .sclk_pad_i (sclk),
        .mosi_pad_i (mosi),
        .miso_pad_o (miso),
        .miso_oe_o  (miso_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host-side observers
    logic [7:0] rx_log[$];
    int         unf_cnt  = 0;
    int         rdy_rise = 0;
    logic       rdy_prev = 1'b1;

    always @(negedge clk) begin
        if (rx_vld === 1'b1) rx_log.push_back(rx_dat);
        if (tx_unf === 1'b1) unf_cnt++;
        if (tx_rdy === 1'b1 && rdy_prev !== 1'b1) rdy_rise++;
        rdy_prev = tx_rdy;
    end

    // Host TX feeder: writes queued words whenever the holding register is free
    logic [7:0] feed_q[$];

    initial begin
        tx_vld = 1'b0;
        tx_dat = '0;
        forever begin
            @(negedge clk);
            tx_vld = 1'b0;
            if (rst === 1'b0 && tx_rdy === 1'b1 && feed_q.size() > 0) begin
                tx_dat = feed_q.pop_front();
                tx_vld = 1'b1;
            end
        end
    end

    // Master model: mo_w is sent on mosi, mi_w collects miso
    logic [7:0] mo_w[4];
    logic [7:0] mi_w[4];

    function automatic int bpos(input bit l, input int i);
        return l ? i : 7 - i;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start(input bit cp, input bit ch, input bit lb);
        cpol = cp;
        cpha = ch;
        lsb  = lb;
        sclk = cp;
        tick(8);
        mosi = ch ? 1'b0 : mo_w[0][bpos(lb, 0)];
        ss   = 1'b0;
        tick(8);
    endtask

    task automatic spi_bits(input bit cp, input bit ch, input bit lb, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int w;
            int i;
            w = k / 8;
            i = k % 8;
            if (!ch) begin
                mi_w[w][bpos(lb, i)] = miso;
                sclk = ~cp;
                tick(4);
                sclk = cp;
                if (k + 1 < nbits) mosi = mo_w[(k + 1) / 8][bpos(lb, (k + 1) % 8)];
                tick(4);
            end else begin
                sclk = ~cp;
                mosi = mo_w[w][bpos(lb, i)];
                tick(4);
                mi_w[w][bpos(lb, i)] = miso;
                sclk = cp;
                tick(4);
            end
        end
    endtask

    task automatic spi_stop();
        tick(4);
        ss = 1'b1;
        tick(8);
    endtask

    // One transfer of nw words. The slave reloads after every finished word
    // while ss is low, so one extra pad word is fed and consumed at the end.
    task automatic run_case(input string tag, input bit cp, input bit ch, input bit lb,
                            input int nw, input bit fixed);
        logic [7:0] exp_tx[4];
        int rx_base, unf_base, rise_base;
        for (int w = 0; w < nw; w++) begin
            exp_tx[w] = (fixed && w == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            mo_w[w]   = (fixed && w == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            mi_w[w]   = 8'hxx;
            feed_q.push_back(exp_tx[w]);
        end
        feed_q.push_back(8'($urandom_range(0, 255)));
        tick(4);
        rx_base   = rx_log.size();
        unf_base  = unf_cnt;
        rise_base = rdy_rise;
        spi_start(cp, ch, lb);
        spi_bits(cp, ch, lb, nw * 8);
        spi_stop();
        for (int w = 0; w < nw; w++) begin
            logic [7:0] got;
            got = (rx_base + w < rx_log.size()) ? rx_log[rx_base + w] : 8'hxx;
            check_val({tag, "_miso"}, 32'(mi_w[w]), 32'(exp_tx[w]));
            check_val({tag, "_rx"}, 32'(got), 32'(mo_w[w]));
        end
        check_val({tag, "_rx_pulses"}, rx_log.size() - rx_base, nw);
        check_val({tag, "_unf_pulses"}, unf_cnt - unf_base, 0);
        check_val({tag, "_rdy_rises"}, rdy_rise - rise_base, nw + 1);
        check_val({tag, "_oe_after"}, 32'(miso_oe), 0);
        check_val({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_miso"}, 32'(miso), 0);
        check_val({tag, "_oe"}, 32'(miso_oe), 0);
        check_val({tag, "_rx_dat"}, 32'(rx_dat), 0);
        check_val({tag, "_rx_vld"}, 32'(rx_vld), 0);
        check_val({tag, "_unf"}, 32'(tx_unf), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_rdy"}, 32'(tx_rdy), 1);
    endtask

    initial begin
        int rx_base, unf_base;
        bit cp, ch, lb;
        rst  = 1'b1;
        cpol = 1'b0;
        cpha = 1'b0;
        lsb  = 1'b0;
        ss   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(4);

        run_case("spec_m0", 1'b0, 1'b0, 1'b0, 1, 1'b1);

        for (int m = 0; m < 4; m++) begin
            for (int l = 0; l < 2; l++) begin
                run_case($sformatf("mode%0d_lsb%0d", m, l), m[1], m[0], l[0], 1, 1'b0);
            end
        end

        run_case("burst3", 1'b0, 1'b0, 1'b0, 3, 1'b0);
        for (int r = 0; r < 4; r++) begin
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            lb = 1'($urandom_range(0, 1));
            run_case($sformatf("rand%0d", r), cp, ch, lb, int'($urandom_range(1, 3)), 1'b0);
        end

        // Underflow: hold empty at ss fall, 0x77 written afterwards goes out as word 2
        mo_w[0] = 8'($urandom_range(0, 255));
        mo_w[1] = 8'($urandom_range(0, 255));
        mi_w[0] = 8'hxx;
        mi_w[1] = 8'hxx;
        rx_base  = rx_log.size();
        unf_base = unf_cnt;
        fork
            begin
                spi_start(1'b0, 1'b0, 1'b0);
                spi_bits(1'b0, 1'b0, 1'b0, 16);
                spi_stop();
            end
            begin
                tick(20);
                feed_q.push_back(8'h77);
                feed_q.push_back(8'h11);
            end
        join
        check_val("unf_word1_miso", 32'(mi_w[0]), 32'h00);
        check_val("unf_word2_miso", 32'(mi_w[1]), 32'h77);
        check_val("unf_pulses", unf_cnt - unf_base, 1);
        check_val("unf_rx_pulses", rx_log.size() - rx_base, 2);
        check_val("unf_rx_w2", (rx_log.size() >= rx_base + 2) ? 32'(rx_log[rx_base + 1]) : 32'hx,
                  32'(mo_w[1]));

        // Abort after 5 bits
        cp = 1'($urandom_range(0, 1));
        ch = 1'($urandom_range(0, 1));
        mo_w[0] = 8'($urandom_range(0, 255));
        feed_q.push_back(8'hC3);
        tick(4);
        rx_base = rx_log.size();
        spi_start(cp, ch, 1'b0);
        spi_bits(cp, ch, 1'b0, 5);
        tick(4);
        check_val("abort_oe_before", 32'(miso_oe), 1);
        ss = 1'b1;
        tick(SYNC_STAGES + 2);
        check_val("abort_oe", 32'(miso_oe), 0);
        check_val("abort_busy", 32'(busy), 0);
        tick(8);
        check_val("abort_rx_pulses", rx_log.size() - rx_base, 0);
        run_case("after_abort", cp, ch, 1'b1, 1, 1'b0);

        // Reset in the middle of a word, with a second word waiting in hold
        mo_w[0] = 8'($urandom_range(0, 255));
        feed_q.push_back(8'h5A);
        tick(4);
        spi_start(1'b0, 1'b0, 1'b0);
        feed_q.push_back(8'h99);
        tick(4);
        check_val("rst_pre_rdy", 32'(tx_rdy), 0);
        spi_bits(1'b0, 1'b0, 1'b0, 3);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midword_rst");
        rst = 1'b0;
        ss  = 1'b1;
        tick(8);
        run_case("after_rst", 1'b1, 1'b1, 1'b0, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
